memory_port_arbiter: RTL and testbench

Shares one single-ported memory interface between the instruction-fetch requester and the data load/store requester of a core. It grants one request at a time, drives the shared memory port with registered commands, and steers the read response back to the requester that owns the outstanding transaction. Its per-port ready/valid outputs are the fetch and memory handshake signals consumed by the hazard detection logic, so stalls follow directly from arbitration.

---
 rtl/memory_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory between fetch and data requesters,
// one transaction in flight. Build macro MEMORY_ARBITER_FAIRNESS_EN bounds data grants while a fetch waits.
module memory_port_arbiter #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int MAX_DATA_GRANTS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_read,
  input  logic [ADDRESS_BITS-1:0] i_address,
  output logic                    i_ready,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_data,
  output logic [ADDRESS_BITS-1:0] i_address_out,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDRESS_BITS-1:0] d_address,
  input  logic [DATA_WIDTH-1:0]   d_data_in,
  output logic                    d_ready,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic [ADDRESS_BITS-1:0] d_address_out,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_data_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_I, WAIT_D} state_t;

  state_t                  state_q;
  logic                    req_fetch_q;
  logic                    mem_read_q, mem_write_q;
  logic [ADDRESS_BITS-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0]   mem_data_out_q;
  logic                    i_valid_q, d_valid_q;
  logic [DATA_WIDTH-1:0]   i_data_q, d_data_q;
  logic [ADDRESS_BITS-1:0] i_address_out_q, d_address_out_q;

  logic d_req_d;
  logic accept_d;
  logic grant_fetch_d;
  logic unused_cfg;

  assign unused_cfg = ^{CORE[0], MAX_DATA_GRANTS[0]};

  // A simultaneous read and write from the data port is a write.
  assign d_req_d  = d_read | d_write;
  assign i_ready  = (state_q == IDLE) & mem_ready;
  assign d_ready  = (state_q == IDLE) & mem_ready;
  assign accept_d = (state_q == IDLE) & mem_ready & (i_read | d_req_d);

`ifdef MEMORY_ARBITER_FAIRNESS_EN
  logic [3:0] grant_cnt_q;

  // Fetch overrides data priority once the run of data grants reaches the limit.
  assign grant_fetch_d = i_read & (~d_req_d | (grant_cnt_q == 4'(MAX_DATA_GRANTS)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
    end else if (accept_d) begin
      if (grant_fetch_d || !i_read) begin
        grant_cnt_q <= '0;
      end else begin
        grant_cnt_q <= grant_cnt_q + 4'd1;
      end
    end
  end
`else
  assign grant_fetch_d = i_read & ~d_req_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_fetch_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_data_out_q  <= '0;
      i_valid_q       <= 1'b0;
      d_valid_q       <= 1'b0;
      i_data_q        <= '0;
      d_data_q        <= '0;
      i_address_out_q <= '0;
      d_address_out_q <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q     <= ISSUE;
            req_fetch_q <= grant_fetch_d;
            if (grant_fetch_d) begin
              mem_address_q <= i_address;
              mem_read_q    <= 1'b1;
            end else begin
              mem_address_q  <= d_address;
              mem_data_out_q <= d_data_in;
              mem_write_q    <= d_write;
              mem_read_q     <= ~d_write;
            end
          end
        end
        ISSUE: begin
          if (mem_write_q) begin
            state_q <= IDLE;
          end else if (req_fetch_q) begin
            state_q <= WAIT_I;
          end else begin
            state_q <= WAIT_D;
          end
        end
        WAIT_I: begin
          if (mem_valid) begin
            i_data_q        <= mem_data_in;
            i_address_out_q <= mem_address_q;
            i_valid_q       <= 1'b1;
            state_q         <= IDLE;
          end
        end
        WAIT_D: begin
          if (mem_valid) begin
            d_data_q        <= mem_data_in;
            d_address_out_q <= mem_address_q;
            d_valid_q       <= 1'b1;
            state_q         <= IDLE;
          end
        end
      endcase
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_data_out  = mem_data_out_q;
  assign i_valid       = i_valid_q;
  assign i_data        = i_data_q;
  assign i_address_out = i_address_out_q;
  assign d_valid       = d_valid_q;
  assign d_data        = d_data_q;
  assign d_address_out = d_address_out_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: variable-latency memory model plus a
// response scoreboard; expected fetch/load responses are queued when the read is issued.
module tb_memory_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          i_ready, i_valid;
  logic [DW-1:0] i_data;
  logic [AW-1:0] i_address_out;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_data_in = '0;
  logic          d_ready, d_valid;
  logic [DW-1:0] d_data;
  logic [AW-1:0] d_address_out;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;
  logic          mem_ready = 1'b1;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_data_in = '0;

  memory_port_arbiter #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MAX_DATA_GRANTS(4)
  ) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid),
    .i_data(i_data), .i_address_out(i_address_out),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_data_in(d_data_in),
    .d_ready(d_ready), .d_valid(d_valid), .d_data(d_data), .d_address_out(d_address_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_data_in(mem_data_in)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          port;   // 1 = fetch, 0 = data
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mem_lat = 2;
  int   mem_wait = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 20'h00040) return 32'h00500093;
    return {12'hC0D, a};
  endfunction

  // Memory: answers a read command L cycles after it is seen (mem_valid at issue+L).
  always @(posedge clock) begin
    mem_valid <= 1'b0;
    if (mem_read === 1'b1) begin
      mem_data_in <= mem_word(mem_address);
      if (mem_lat <= 1) mem_valid <= 1'b1;
      else mem_wait <= mem_lat - 1;
    end else if (mem_wait > 0) begin
      mem_wait <= mem_wait - 1;
      if (mem_wait == 1) mem_valid <= 1'b1;
    end
  end

  // Response scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset !== 1'b1 && (i_valid === 1'b1 || d_valid === 1'b1)) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got i_valid=%0b d_valid=%0b, required no response", i_valid, d_valid);
      end else begin
        e = sb_q.pop_front();
        if (e.port) begin
          if (i_valid !== 1'b1 || d_valid !== 1'b0 || i_data !== e.data || i_address_out !== e.addr) begin
            n_fail++;
            $display("FAIL resp_fetch: got iv=%0b dv=%0b addr=%h data=%h, required fetch addr=%h data=%h",
                     i_valid, d_valid, i_address_out, i_data, e.addr, e.data);
          end else $display("[TB] fetch resp addr=%h data=%h", i_address_out, i_data);
        end else begin
          if (d_valid !== 1'b1 || i_valid !== 1'b0 || d_data !== e.data || d_address_out !== e.addr) begin
            n_fail++;
            $display("FAIL resp_load: got iv=%0b dv=%0b addr=%h data=%h, required load addr=%h data=%h",
                     i_valid, d_valid, d_address_out, d_data, e.addr, e.data);
          end else $display("[TB] load resp addr=%h data=%h", d_address_out, d_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({i_valid, d_valid, mem_read, mem_write} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, required 0000", {i_valid, d_valid, mem_read, mem_write});
    end
    n_tests++;
    if ({i_data, d_data, i_address_out, d_address_out, mem_address, mem_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: got i_data=%h d_data=%h mem_addr=%h, required all 0", i_data, d_data, mem_address);
    end
    n_tests++;
    if (i_ready !== 1'b1 || d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_hi: got %b%b, required 11", i_ready, d_ready);
    end
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_lo: got %b%b, required 00", i_ready, d_ready);
    end
    mem_ready = 1'b1;
    reset = 1'b0;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_fetch_read();
    int c;
    mem_lat = 2;
    i_read = 1'b1;
    i_address = 20'h00040;
    #1;
    n_tests++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_ready: got %b, required 1", i_ready);
    end
    tick();
    i_read = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 20'h00040) begin
      n_fail++;
      $display("FAIL fetch_issue: got rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=00040", mem_read, mem_write, mem_address);
    end
    sb_q.push_back('{port: 1'b1, addr: 20'h00040, data: 32'h00500093});
    c = 1;
    while (i_valid !== 1'b1 && c < 12) begin
      tick();
      c++;
    end
    n_tests++;
    if (c != 4) begin
      n_fail++;
      $display("FAIL fetch_latency: got i_valid at +%0d, required +4", c);
    end
    tick();
  endtask

  task automatic test_priority();
    int c;
    bit early;
    mem_lat = 1;
    i_read = 1'b1;
    i_address = 20'h00200;
    d_read = 1'b1;
    d_address = 20'h00080;
    #1;
    tick();
    d_read = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1 || mem_address !== 20'h00080) begin
      n_fail++;
      $display("FAIL prio_data_first: got rd=%b addr=%h, required rd=1 addr=00080", mem_read, mem_address);
    end
    sb_q.push_back('{port: 1'b0, addr: 20'h00080, data: mem_word(20'h00080)});
    tick();
    c = 0;
    early = 1'b0;
    while (d_valid !== 1'b1 && c < 20) begin
      if (mem_read === 1'b1) early = 1'b1;
      tick();
      c++;
    end
    n_tests++;
    if (c >= 20 || early || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_wait: got timeout=%0b early_fetch=%0b i_ready=%b, required 0 0 1", c >= 20, early, i_ready);
    end
    tick();
    i_read = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1 || mem_address !== 20'h00200) begin
      n_fail++;
      $display("FAIL prio_fetch_next: got rd=%b addr=%h, required rd=1 addr=00200", mem_read, mem_address);
    end
    sb_q.push_back('{port: 1'b1, addr: 20'h00200, data: mem_word(20'h00200)});
    c = 0;
    while (i_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= 20) begin
      n_fail++;
      $display("FAIL prio_fetch_resp: got no i_valid in 20 cycles, required one");
    end
    tick();
  endtask

  task automatic test_write();
    int dv;
    d_write = 1'b1;
    d_address = 20'h00100;
    d_data_in = 32'hDEADBEEF;
    #1;
    tick();
    d_write = 1'b0;
    n_tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 20'h00100 || mem_data_out !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_issue: got wr=%b rd=%b addr=%h data=%h, required 1 0 00100 deadbeef",
               mem_write, mem_read, mem_address, mem_data_out);
    end
    n_tests++;
    if (d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ready_busy: got %b, required 0", d_ready);
    end
    tick();
    n_tests++;
    if (mem_write !== 1'b0 || d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_done: got wr=%b d_ready=%b, required 0 1", mem_write, d_ready);
    end
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 20'h00104;
    d_data_in = 32'h12345678;
    tick();
    d_read = 1'b0;
    d_write = 1'b0;
    n_tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 20'h00104 || mem_data_out !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rw_is_write: got wr=%b rd=%b addr=%h data=%h, required 1 0 00104 12345678",
               mem_write, mem_read, mem_address, mem_data_out);
    end
    dv = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (d_valid === 1'b1) dv++;
    end
    n_tests++;
    if (dv != 0) begin
      n_fail++;
      $display("FAIL write_no_valid: got %0d d_valid pulses, required 0", dv);
    end
    $display("[TB] writes 00100 and 00104 issued");
  endtask

  task automatic test_mem_ready_stall();
    int bad;
    int c;
    mem_lat = 3;
    mem_ready = 1'b0;
    i_read = 1'b1;
    i_address = 20'h00300;
    #1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (i_ready !== 1'b0 || d_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d bad cycles, required 0", bad);
    end
    mem_ready = 1'b1;
    #1;
    tick();
    i_read = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1 || mem_address !== 20'h00300) begin
      n_fail++;
      $display("FAIL stall_release: got rd=%b addr=%h, required rd=1 addr=00300", mem_read, mem_address);
    end
    sb_q.push_back('{port: 1'b1, addr: 20'h00300, data: mem_word(20'h00300)});
    c = 0;
    while (i_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= 20) begin
      n_fail++;
      $display("FAIL stall_resp: got no i_valid in 20 cycles, required one");
    end
    tick();
  endtask

  task automatic test_fairness();
    int g;
    int c;
    bit exp_f;
    logic [AW-1:0] exp_a;
    mem_lat = 1;
    d_read = 1'b1;
    d_address = 20'h00800;
    i_read = 1'b1;
    i_address = 20'h00900;
    g = 0;
    c = 0;
    while (g < 10 && c < 200) begin
      tick();
      c++;
      if (mem_read === 1'b1) begin
`ifdef MEMORY_ARBITER_FAIRNESS_EN
        exp_f = ((g % 5) == 4);
`else
        exp_f = 1'b0;
`endif
        exp_a = exp_f ? 20'h00900 : 20'h00800;
        sb_q.push_back('{port: exp_f, addr: exp_a, data: mem_word(exp_a)});
        n_tests++;
        if (mem_address !== exp_a) begin
          n_fail++;
          $display("FAIL fair_grant%0d: got addr=%h, required %h", g, mem_address, exp_a);
        end
        g++;
      end
    end
    n_tests++;
    if (g < 10) begin
      n_fail++;
      $display("FAIL fair_timeout: got %0d grants, required 10", g);
    end
    d_read = 1'b0;
    i_read = 1'b0;
    c = 0;
    while (sb_q.size() != 0 && c < 20) begin
      tick();
      c++;
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int bad;
    mem_lat = 4;
    d_read = 1'b1;
    d_address = 20'h00444;
    #1;
    tick();
    d_read = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if ({d_valid, i_valid, mem_read, mem_write} !== 4'b0 || d_ready !== 1'b1 ||
        {d_data, d_address_out, i_data, i_address_out, mem_address, mem_data_out} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got dv=%b rd=%b d_ready=%b d_data=%h mem_addr=%h, required reset values",
               d_valid, mem_read, d_ready, d_data, mem_address);
    end
    tick();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (d_valid !== 1'b0 || i_valid !== 1'b0 || mem_read !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_stale: got %0d cycles with activity, required 0", bad);
    end
    n_tests++;
    if (i_ready !== 1'b1 || d_ready !== 1'b1 || d_data !== '0 || d_address_out !== '0) begin
      n_fail++;
      $display("FAIL midreset_idle: got rdy=%b%b d_data=%h d_addr=%h, required 11 0 0", i_ready, d_ready, d_data, d_address_out);
    end
    $display("[TB] reset mid-load handled");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_read();
    test_priority();
    test_write();
    test_mem_ready_stall();
    test_fairness();
    test_reset_midflight();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d outstanding responses, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
